// File: rtl/line_fill_unit_pkg.sv
// Shared cache definitions: the line fill FSM encoding and the
// beats-per-line derivation, kept here so the cache controller can reuse them.
package line_fill_unit_pkg;

  localparam int LFU_STATE_W = 3;

  typedef enum logic [LFU_STATE_W-1:0] {
    LFU_IDLE    = 3'd0,
    LFU_REQ     = 3'd1,
    LFU_COLLECT = 3'd2,
    LFU_WRITE   = 3'd3,
    LFU_DONE    = 3'd4
  } lfu_state_t;

  // Number of memory beats that make up one cache line.
  function automatic int lfu_beats(input int data_width, input int bus_width);
    return data_width / bus_width;
  endfunction

endpackage

// File: rtl/line_fill_unit.sv
// Line fill unit: fetches one cache line from memory as BEATS bus beats,
// assembles it (beat 0 in the LSBs) and writes it to the line SRAM in one cycle.
//
// Handshakes:
//   request side : req_i is taken only in a cycle where req_ready_o = 1; the
//                  requester holds req_i (and its index/address) until then.
//   memory side  : mem_strobe_o stays high until the cycle with mem_ready_i = 1
//                  (the address is accepted at that edge); afterwards every
//                  cycle with mem_valid_i = 1 delivers exactly one beat, and a
//                  beat may arrive in the acceptance cycle itself.
//   flush_i      : before acceptance it cancels the request outright; after
//                  acceptance the remaining beats are still drained so the
//                  bus stays aligned, and the line is discarded.
module line_fill_unit
  import line_fill_unit_pkg::*;
#(
  parameter int N_ENTRIES  = 1024,
  parameter int DATA_WIDTH = 256,
  parameter int BUS_WIDTH  = 32,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [IDX_W-1:0]      req_idx_i,
  input  logic [31:0]           req_addr_i,
  output logic                  req_ready_o,
  input  logic                  flush_i,
  output logic                  mem_strobe_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_valid_i,
  input  logic [BUS_WIDTH-1:0]  mem_data_i,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [IDX_W-1:0]      sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [2:0]            state_o
);

  localparam int BEATS = lfu_beats(DATA_WIDTH, BUS_WIDTH);
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  lfu_state_t            state_q;
  lfu_state_t            state_d;
  logic [K_W-1:0]        k_q;
  logic                  abort_q;
  logic                  full_q;
  logic [IDX_W-1:0]      idx_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] line_q;

  logic                  accept;
  logic                  capture;
  logic                  set_abort;
  logic                  last_beat;

  assign accept     = (state_q == LFU_IDLE) && req_i;
  assign last_beat  = (k_q == K_W'(BEATS - 1));
  assign mem_addr_o = addr_q;
  assign state_o    = state_q;

  // Next-state decode, beat capture strobe and abort request.
  // full_q marks the extra COLLECT cycle that follows the last beat; the
  // decision to write or discard the line is taken from there, except that an
  // aborted fill leaves for IDLE right at the last beat.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    set_abort = 1'b0;
    case (state_q)
      LFU_IDLE: begin
        if (req_i) state_d = LFU_REQ;
      end
      LFU_REQ: begin
        if (mem_ready_i) begin
          state_d   = LFU_COLLECT;
          capture   = mem_valid_i;
          set_abort = flush_i;
        end else if (flush_i) begin
          state_d = LFU_IDLE;
        end
      end
      LFU_COLLECT: begin
        if (full_q) begin
          state_d = (abort_q || flush_i) ? LFU_IDLE : LFU_WRITE;
        end else begin
          set_abort = flush_i;
          if (mem_valid_i) begin
            capture = 1'b1;
            if (last_beat && (abort_q || flush_i)) state_d = LFU_IDLE;
          end
        end
      end
      LFU_WRITE: state_d = LFU_DONE;
      LFU_DONE:  state_d = LFU_IDLE;
      default:   state_d = LFU_IDLE;
    endcase
  end

  // FSM state, beat counter, abort flag and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LFU_IDLE;
      k_q          <= '0;
      abort_q      <= 1'b0;
      full_q       <= 1'b0;
      mem_strobe_o <= 1'b0;
      sram_en_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      req_ready_o  <= 1'b1;
    end else begin
      state_q      <= state_d;
      mem_strobe_o <= (state_d == LFU_REQ);
      sram_en_o    <= (state_d == LFU_WRITE);
      sram_we_o    <= (state_d == LFU_WRITE);
      done_o       <= (state_d == LFU_DONE);
      busy_o       <= (state_d != LFU_IDLE);
      req_ready_o  <= (state_d == LFU_IDLE);
      full_q       <= (state_d == LFU_COLLECT) && (full_q || (capture && last_beat));

      if (accept) begin
        k_q     <= '0;
        abort_q <= 1'b0;
      end else begin
        if (capture) k_q <= last_beat ? '0 : k_q + K_W'(1);
        if (set_abort) abort_q <= 1'b1;
      end
    end
  end

  // Datapath: request latch, line assembly and the SRAM write registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= req_idx_i;
      addr_q <= req_addr_i;
    end
    if (capture) line_q[k_q*BUS_WIDTH +: BUS_WIDTH] <= mem_data_i;
    if (state_d == LFU_WRITE) begin
      sram_addr_o <= idx_q;
      sram_data_o <= line_q;
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit.
module tb_line_fill_unit;
  import line_fill_unit_pkg::*;

  localparam int N_ENTRIES  = 1024;
  localparam int DATA_WIDTH = 256;
  localparam int BUS_WIDTH  = 32;
  localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
  localparam int IDX_W      = $clog2(N_ENTRIES);
  localparam int EXP_W      = IDX_W + DATA_WIDTH;

  logic                  clk;
  logic                  rst;
  logic                  req_i;
  logic [IDX_W-1:0]      req_idx_i;
  logic [31:0]           req_addr_i;
  logic                  req_ready_o;
  logic                  flush_i;
  logic                  mem_strobe_o;
  logic [31:0]           mem_addr_o;
  logic                  mem_ready_i;
  logic                  mem_valid_i;
  logic [BUS_WIDTH-1:0]  mem_data_i;
  logic                  sram_en_o;
  logic                  sram_we_o;
  logic [IDX_W-1:0]      sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_data_o;
  logic                  done_o;
  logic                  busy_o;
  logic [2:0]            state_o;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;
  int wr_count = 0;
  int done_count = 0;
  int last_wr_edge = 0;
  int last_done_edge = 0;
  bit auto_data = 0;
  logic [EXP_W-1:0] exp_q[$];

  line_fill_unit #(
    .N_ENTRIES (N_ENTRIES),
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_idx_i   (req_idx_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .mem_strobe_o(mem_strobe_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .sram_en_o   (sram_en_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_data_o (sram_data_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [BUS_WIDTH-1:0] pat(input int n);
    logic [31:0] v;
    v = 32'h9E3779B9 * 32'(n) + 32'h0F1E2D3C;
    return v;
  endfunction

  // Line a back-to-back fill assembles when accepted at edge e with
  // ready/valid held high: beat b is presented while edge_n == e + b.
  function automatic logic [DATA_WIDTH-1:0] line_at(input int e);
    logic [DATA_WIDTH-1:0] l;
    l = '0;
    for (int b = 0; b < BEATS; b++) l[b*BUS_WIDTH +: BUS_WIDTH] = pat(e + b);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_data) mem_data_i = pat(edge_n);
  endtask

  task automatic idle_inputs();
    req_i       = 1'b0;
    flush_i     = 1'b0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    auto_data   = 1'b0;
    mem_data_i  = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (sram_we_o === 1'b1) begin
      wr_count++;
      last_wr_edge = edge_n;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", sram_addr_o, sram_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({sram_addr_o, sram_data_o} !== e) begin
          n_fail++;
          $display("FAIL write_content: got addr=%0d data=%h, required addr=%0d data=%h",
                   sram_addr_o, sram_data_o, e[EXP_W-1 -: IDX_W], e[DATA_WIDTH-1:0]);
        end
      end
      n_cmp++;
      if (sram_en_o !== 1'b1) begin
        n_fail++;
        $display("FAIL write_en: got sram_en_o=%b, required 1", sram_en_o);
      end
    end
    if (done_o === 1'b1) begin
      done_count++;
      last_done_edge = edge_n;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    req_idx_i  = '0;
    req_addr_i = '0;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (state_o !== LFU_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", state_o, LFU_IDLE); end
    n_cmp++; if (mem_strobe_o !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b, required 0", mem_strobe_o); end
    n_cmp++; if (sram_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b, required 0", sram_en_o); end
    n_cmp++; if (sram_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", sram_we_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", req_ready_o); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [DATA_WIDTH-1:0] line;
    int w0, d0, e_acc;
    for (int b = 0; b < BEATS; b++) line[b*BUS_WIDTH +: BUS_WIDTH] = 32'h11111111 * (b + 1);
    exp_q.push_back({IDX_W'(5), line});
    w0 = wr_count; d0 = done_count;
    req_idx_i = IDX_W'(5); req_addr_i = 32'h1000;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1;
    mem_data_i = 32'hDEADBEEF;  // valid in IDLE must be ignored
    req_i = 1'b1;
    tick();
    e_acc = edge_n;
    req_i = 1'b0;
    mem_data_i = 32'h11111111;
    n_cmp++; if (mem_strobe_o !== 1'b1) begin n_fail++; $display("FAIL basic_strobe: got %b, required 1", mem_strobe_o); end
    n_cmp++; if (mem_addr_o !== 32'h1000) begin n_fail++; $display("FAIL basic_mem_addr: got %h, required 00001000", mem_addr_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_ready_busy: got %b, required 0", req_ready_o); end
    for (int b = 1; b < BEATS; b++) begin
      tick();
      mem_data_i = 32'h11111111 * (b + 1);
    end
    tick();
    mem_data_i = 32'hBADBADBA;  // beyond the line, must not be captured
    for (int i = 0; i < 20 && done_count == d0; i++) tick();
    idle_inputs();
    n_cmp++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL basic_write_count: got %0d, required 1", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, required 1", done_count - d0); end
    n_cmp++; if (last_wr_edge - e_acc + 1 !== 10) begin n_fail++; $display("FAIL basic_write_cycle: got %0d, required 10", last_wr_edge - e_acc + 1); end
    n_cmp++; if (last_done_edge - e_acc + 1 !== 11) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, required 11", last_done_edge - e_acc + 1); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b, required 1", req_ready_o); end
  endtask

  task automatic test_backpressure();
    logic [BUS_WIDTH-1:0] beat [BEATS];
    logic [DATA_WIDTH-1:0] line;
    int w0, d0, sent;
    for (int b = 0; b < BEATS; b++) begin
      beat[b] = BUS_WIDTH'($urandom);
      line[b*BUS_WIDTH +: BUS_WIDTH] = beat[b];
    end
    exp_q.push_back({IDX_W'(12), line});
    w0 = wr_count; d0 = done_count;
    req_idx_i = IDX_W'(12); req_addr_i = 32'h2040;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && sent < BEATS; c++) begin
      mem_ready_i = (c >= 3);
      mem_valid_i = (c >= 3) && (((c - 3) % 2) == 0);
      mem_data_i  = mem_valid_i ? beat[sent] : BUS_WIDTH'($urandom);
      tick();
      if (mem_valid_i) sent++;
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_busy: cycle %0d got %b, required 1", c, busy_o); end
    end
    mem_ready_i = 1'b0; mem_valid_i = 1'b0;
    for (int i = 0; i < 20 && done_count == d0; i++) begin
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_busy_tail: got %b, required 1", busy_o); end
      tick();
    end
    n_cmp++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL bp_write_count: got %0d, required 1", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d, required 1", done_count - d0); end
  endtask

  task automatic test_flush_collect();
    int w0, d0;
    w0 = wr_count; d0 = done_count;
    req_idx_i = IDX_W'(20); req_addr_i = 32'h3000;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      mem_data_i = BUS_WIDTH'($urandom);
      flush_i = (b == 4);
      tick();
      flush_i = 1'b0;
      if (b < BEATS - 1) begin
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL flc_draining: beat %0d got ready=%b, required 0", b, req_ready_o); end
      end else begin
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL flc_ready_after_last: got %b, required 1", req_ready_o); end
        n_cmp++; if (state_o !== LFU_IDLE) begin n_fail++; $display("FAIL flc_state: got %0d, required %0d", state_o, LFU_IDLE); end
      end
    end
    idle_inputs();
    repeat (4) tick();
    n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL flc_write_count: got %0d, required 0", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 0) begin n_fail++; $display("FAIL flc_done_count: got %0d, required 0", done_count - d0); end
  endtask

  task automatic test_flush_req();
    int w0, d0, e_acc;
    w0 = wr_count; d0 = done_count;
    req_idx_i = IDX_W'(33); req_addr_i = 32'h4000;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    n_cmp++; if (mem_strobe_o !== 1'b1) begin n_fail++; $display("FAIL flr_strobe_up: got %b, required 1", mem_strobe_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_cmp++; if (mem_strobe_o !== 1'b0) begin n_fail++; $display("FAIL flr_strobe_drop: got %b, required 0", mem_strobe_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL flr_ready: got %b, required 1", req_ready_o); end
    repeat (2) tick();
    n_cmp++; if (wr_count - w0 !== 0) begin n_fail++; $display("FAIL flr_no_write: got %0d, required 0", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 0) begin n_fail++; $display("FAIL flr_no_done: got %0d, required 0", done_count - d0); end
    // follow-up fill to idx 7 must complete normally
    req_idx_i = IDX_W'(7); req_addr_i = 32'h4100;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1;
    auto_data = 1'b1; mem_data_i = pat(edge_n);
    req_i = 1'b1;
    tick();
    e_acc = edge_n;
    req_i = 1'b0;
    exp_q.push_back({IDX_W'(7), line_at(e_acc)});
    for (int i = 0; i < 20 && done_count == d0; i++) tick();
    idle_inputs();
    n_cmp++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL flr_refill_write: got %0d, required 1", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 1) begin n_fail++; $display("FAIL flr_refill_done: got %0d, required 1", done_count - d0); end
  endtask

  task automatic test_reset_write();
    int d0, e_acc;
    d0 = done_count;
    req_idx_i = IDX_W'(99); req_addr_i = 32'h5000;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1;
    auto_data = 1'b1; mem_data_i = pat(edge_n);
    req_i = 1'b1;
    tick();
    e_acc = edge_n;
    req_i = 1'b0;
    exp_q.push_back({IDX_W'(99), line_at(e_acc)});
    for (int i = 0; i < 20 && sram_we_o !== 1'b1; i++) tick();
    n_cmp++; if (sram_we_o !== 1'b1) begin n_fail++; $display("FAIL rw_reach_write: got we=%b, required 1", sram_we_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (state_o !== LFU_IDLE) begin n_fail++; $display("FAIL rw_state: got %0d, required %0d", state_o, LFU_IDLE); end
    n_cmp++; if (sram_we_o !== 1'b0 || sram_en_o !== 1'b0) begin n_fail++; $display("FAIL rw_sram: got en=%b we=%b, required 0 0", sram_en_o, sram_we_o); end
    n_cmp++; if (mem_strobe_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rw_ctrl: got strobe=%b busy=%b, required 0 0", mem_strobe_o, busy_o); end
    n_cmp++; if (req_ready_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL rw_ready_done: got ready=%b done=%b, required 1 0", req_ready_o, done_o); end
    rst = 1'b0;
    idle_inputs();
    repeat (3) tick();
    n_cmp++; if (done_count - d0 !== 0) begin n_fail++; $display("FAIL rw_no_done: got %0d, required 0", done_count - d0); end
  endtask

  task automatic test_back_to_back();
    int w0, d0, e1, e2;
    w0 = wr_count; d0 = done_count;
    req_idx_i = IDX_W'(0); req_addr_i = 32'h6000;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1;
    auto_data = 1'b1; mem_data_i = pat(edge_n);
    req_i = 1'b1;
    for (int i = 0; i < 5 && req_ready_o === 1'b1; i++) tick();
    e1 = edge_n;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_accept1: got ready=%b, required 0", req_ready_o); end
    exp_q.push_back({IDX_W'(0), line_at(e1)});
    req_idx_i = IDX_W'(N_ENTRIES - 1); req_addr_i = 32'h7000;
    for (int i = 0; i < 30 && req_ready_o !== 1'b1; i++) tick();
    n_cmp++; if (edge_n - e1 + 1 !== 12) begin n_fail++; $display("FAIL b2b_idle_cycle: got cycle %0d, required 12", edge_n - e1 + 1); end
    tick();
    e2 = edge_n;
    req_i = 1'b0;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_accept2: got ready=%b, required 0", req_ready_o); end
    n_cmp++; if (mem_addr_o !== 32'h7000) begin n_fail++; $display("FAIL b2b_mem_addr: got %h, required 00007000", mem_addr_o); end
    exp_q.push_back({IDX_W'(N_ENTRIES - 1), line_at(e2)});
    for (int i = 0; i < 20 && done_count - d0 < 2; i++) tick();
    idle_inputs();
    n_cmp++; if (wr_count - w0 !== 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d, required 2", wr_count - w0); end
    n_cmp++; if (done_count - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d, required 2", done_count - d0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_collect();
    test_flush_req();
    test_reset_write();
    test_back_to_back();
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fill_unit.md
LINE_FILL_UNIT -- requirements
Module: line_fill_unit

Interface
REQ-001 Parameter N_ENTRIES, default 1024, SHALL set the number of cache lines; index width is clog2(N_ENTRIES).
REQ-002 Parameter DATA_WIDTH, default 256, SHALL set the line width in bits.
REQ-003 Parameter BUS_WIDTH, default 32, SHALL set the memory beat width; BEATS = DATA_WIDTH/BUS_WIDTH, default 8, must be an integer ≥2.
REQ-004 Ports (name  direction  width  meaning):
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-high reset
 req_i  in  1  fill request
 req_idx_i  in  clog2(N_ENTRIES)  destination line index
 req_addr_i  in  32  line base byte address
 req_ready_o  out  1  unit idle, can accept a request
 flush_i  in  1  abort the current fill
 mem_strobe_o  out  1  memory read request
 mem_addr_o  out  32  memory read address, equal to the latched req_addr_i
 mem_ready_i  in  1  memory accepted the request
 mem_valid_i  in  1  one beat valid on mem_data_i
 mem_data_i  in  BUS_WIDTH  beat data
 sram_en_o  out  1  to sram en
 sram_we_o  out  1  to sram we
 sram_addr_o  out  clog2(N_ENTRIES)  to sram addr
 sram_data_o  out  DATA_WIDTH  to sram data_i
 done_o  out  1  one-cycle pulse: line written
 busy_o  out  1  high in any state other than IDLE

Function
REQ-005 The FSM SHALL have the states IDLE, REQ, COLLECT, WRITE and DONE, held in a registered state variable.
REQ-006 IDLE: req_ready_o = 1. When req_i = 1, the unit SHALL latch req_idx_i and req_addr_i, clear the beat counter and go to REQ.
REQ-007 REQ: mem_strobe_o SHALL be held high until the cycle in which mem_ready_i = 1; the unit then goes to COLLECT.
REQ-008 If mem_valid_i = 1 in the same cycle as mem_ready_i, that beat SHALL be captured as beat 0.
REQ-009 COLLECT: each cycle with mem_valid_i = 1 SHALL store mem_data_i into line bits [k*BUS_WIDTH +: BUS_WIDTH] and increment k. Beat 0 goes to the LSBs.
REQ-010 Cycles with mem_valid_i = 0 SHALL hold the line buffer and k unchanged. There is no timeout.
REQ-011 When beat BEATS-1 is captured, the FSM SHALL go to WRITE on the next edge. k wraps to 0.
REQ-012 WRITE lasts exactly one cycle: sram_en_o = sram_we_o = 1, sram_addr_o = latched index, sram_data_o = assembled line. The next state is DONE.
REQ-013 DONE lasts exactly one cycle: done_o = 1. The next state is IDLE.
REQ-014 sram_en_o and sram_we_o SHALL be 0 in every state except WRITE. sram_addr_o and sram_data_o are don't-care outside WRITE but SHALL be registered values.
REQ-015 Minimum latency, with mem_ready_i and mem_valid_i held high: request accepted at cycle 0, write at cycle 1+BEATS+1, done_o at cycle BEATS+3.
REQ-016 A req_i arriving outside IDLE SHALL be ignored; the requester must hold req_i until it sees req_ready_o.
REQ-017 flush_i in IDLE, WRITE or DONE SHALL have no effect; a write already issued completes.
REQ-018 flush_i in REQ before acceptance: mem_strobe_o SHALL drop on the next cycle and the FSM returns to IDLE with no write and no done_o.
REQ-019 flush_i in COLLECT, or in REQ in the same cycle as mem_ready_i: the unit SHALL set an abort flag and keep consuming the remaining beats, so the bus stays aligned.
REQ-020 After such an abort, the unit SHALL skip WRITE and DONE and return to IDLE directly after the last beat; sram_we_o and done_o stay 0.
REQ-021 mem_valid_i while in IDLE, REQ (before acceptance), WRITE or DONE SHALL be ignored.

Reset
REQ-022 While rst = 1 at a rising edge: state <= IDLE, k <= 0, abort flag <= 0.
REQ-023 The outputs after reset SHALL be: mem_strobe_o = 0, sram_en_o = 0, sram_we_o = 0, done_o = 0, busy_o = 0, req_ready_o = 1.
REQ-024 The line buffer and latched address/index need no reset.
REQ-025 A reset during any state, including WRITE, SHALL take effect on that edge; no write is issued after the edge.

Structure
REQ-026 The FSM state encoding and the BEATS derivation SHALL be placed in the shared cache package, so the cache controller can reuse them.
REQ-027 The block SHALL be a single module with no sub-module. Its sram_* outputs connect to the sram write port, through the cache controller's port mux.

Verification
REQ-028 Basic fill: idx=5, addr=0x1000, ready/valid always high, beats 0x11111111..0x88888888. Required: one write at cycle 10 with addr 5 and data 0x88888888_..._11111111; done_o at cycle 11.
REQ-029 Back-pressure: mem_ready_i delayed 3 cycles and mem_valid_i toggling 1-0-1-0. Required: the line is correct, exactly one write occurs, and busy_o stays high throughout.
REQ-030 Flush after 4 of 8 beats. Required: all 8 beats are consumed, sram_we_o never rises, done_o stays 0, and req_ready_o returns 1 after the last beat.
REQ-031 Flush in REQ before mem_ready_i. Required: mem_strobe_o drops within 1 cycle, no write occurs, and a new request for idx=7 then completes normally.
REQ-032 rst asserted in the WRITE cycle. Required: FSM in IDLE with all outputs at reset values on the next cycle, and done_o never pulses.
REQ-033 req_i held high continuously with idx=0 then idx=N_ENTRIES-1. Required: two back-to-back fills, each request accepted only in IDLE, with writes to addresses 0 and N_ENTRIES-1.
